rej_uniform_sampler: RTL and testbench

Rejection sampler for Kyber matrix generation. It sits directly downstream of the SHAKE128 squeeze stream and consumes 64-bit output words. It parses each 3-byte group into two 12-bit candidates, keeps the ones below q = 3329, and emits exactly 256 coefficients per polynomial over a valid/ready stream. Any squeeze words left after the 256th coefficient are drained and discarded.

---
 rtl/kyber_pkg.sv | 15 +
 rtl/rej_uniform_sampler.sv | 146 ++++++++++++++
 tb/tb_rej_uniform_sampler.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the rejection-sampler state encoding.
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int BW_DATA = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rej_uniform_sampler.sv
// Kyber uniform rejection sampler: 64-bit squeeze words -> 256 coefficients < Q over valid/ready.
// First coefficient one cycle after the first word; words are held off while the buffer holds > 64 bits.
module rej_uniform_sampler #(
    parameter int BW_DATA = kyber_pkg::BW_DATA,
    parameter int Q       = kyber_pkg::KYBER_Q,
    parameter int N       = kyber_pkg::KYBER_N
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic [BW_DATA-1:0] i_word,
    input  logic               i_word_valid,
    input  logic               i_word_last,
    output logic               o_word_ready,
    output logic [11:0]        o_coef,
    output logic [7:0]         o_coef_idx,
    output logic               o_coef_valid,
    input  logic               i_coef_ready,
    output logic               o_done,
    output logic               o_err
);
    import kyber_pkg::*;

    localparam int NB    = BW_DATA / 8;
    localparam int BUF_W = 2 * BW_DATA;

    state_t             r_state, w_state_nxt;
    logic [BUF_W-1:0]   r_buf, w_buf_nxt, w_buf_shift, w_word_ins;
    logic [BW_DATA-1:0] w_word_le;
    logic [7:0]         r_fill, w_fill_nxt, w_pos;
    logic [8:0]         r_cnt, w_cnt_nxt;
    logic               r_seen_last;
    logic               r_coef_vld;
    logic               r_err;
    logic [11:0]        r_coef;
    logic [7:0]         r_idx;
    logic [11:0]        w_cand;
    logic               w_hs, w_last_hs, w_out_free, w_ext, w_acc, w_starve;

    // Stream byte 0 is the MSB byte of the word; the buffer is LSB-first.
    generate
        for (genvar k = 0; k < NB; k++) begin : g_byte
            assign w_word_le[8*k +: 8] = i_word[BW_DATA-1-8*k -: 8];
        end
    endgenerate

    assign o_word_ready = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && (r_fill <= 8'(BW_DATA));
    assign w_hs         = o_word_ready && i_word_valid;
    assign w_last_hs    = w_hs && i_word_last;
    assign w_out_free   = !r_coef_vld || i_coef_ready;
    assign w_ext        = (r_state == ST_RUN) && (r_fill >= 8'd12) && (r_cnt < 9'(N)) && w_out_free;
    assign w_cand       = r_buf[11:0];
    assign w_acc        = w_ext && (w_cand < 12'(Q));
    assign w_pos        = w_ext ? (r_fill - 8'd12) : r_fill;
    assign w_buf_shift  = w_ext ? (r_buf >> 12) : r_buf;
    assign w_word_ins   = {{(BUF_W-BW_DATA){1'b0}}, w_word_le} << w_pos;
    assign w_starve     = (r_state == ST_RUN) && r_seen_last && (r_fill < 8'd12)
                          && (r_cnt < 9'(N)) && !w_hs;

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_fill_nxt  = r_fill;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                    w_buf_nxt   = '0;
                    w_fill_nxt  = 8'd0;
                    w_cnt_nxt   = 9'd0;
                end
            end
            ST_RUN: begin
                w_buf_nxt  = w_buf_shift | (w_hs ? w_word_ins : '0);
                w_fill_nxt = w_pos + (w_hs ? 8'(BW_DATA) : 8'd0);
                if (w_acc) begin
                    w_cnt_nxt = r_cnt + 9'd1;
                end
                if (w_acc && (r_cnt == 9'(N-1))) begin
                    w_state_nxt = ST_DRAIN;
                    w_buf_nxt   = '0;
                    w_fill_nxt  = 8'd0;
                end else if (w_starve && !r_coef_vld) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if ((r_seen_last || w_last_hs) && !r_coef_vld) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= ST_IDLE;
            r_buf       <= '0;
            r_fill      <= 8'd0;
            r_cnt       <= 9'd0;
            r_seen_last <= 1'b0;
            r_err       <= 1'b0;
            r_coef      <= 12'd0;
            r_idx       <= 8'd0;
            r_coef_vld  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_fill  <= w_fill_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((r_state == ST_IDLE) && i_start) begin
                r_seen_last <= 1'b0;
                r_err       <= 1'b0;
            end else begin
                if (w_last_hs) begin
                    r_seen_last <= 1'b1;
                end
                if (w_starve) begin
                    r_err <= 1'b1;
                end
            end
            // A new load wins over the handshake so valid stays high back-to-back.
            if (w_acc) begin
                r_coef     <= w_cand;
                r_idx      <= r_cnt[7:0];
                r_coef_vld <= 1'b1;
            end else if (r_coef_vld && i_coef_ready) begin
                r_coef_vld <= 1'b0;
            end
        end
    end

    assign o_coef       = r_coef;
    assign o_coef_idx   = r_idx;
    assign o_coef_valid = r_coef_vld;
    assign o_done       = (r_state == ST_DONE);
    assign o_err        = r_err;

endmodule

// File: tb/tb_rej_uniform_sampler.sv
// Scoreboard bench for rej_uniform_sampler: directed and model-derived coefficient streams.
module tb_rej_uniform_sampler;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_start;
    logic [63:0] i_word;
    logic        i_word_valid;
    logic        i_word_last;
    logic        o_word_ready;
    logic [11:0] o_coef;
    logic [7:0]  o_coef_idx;
    logic        o_coef_valid;
    logic        i_coef_ready;
    logic        o_done;
    logic        o_err;

    rej_uniform_sampler dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_start      (i_start),
        .i_word       (i_word),
        .i_word_valid (i_word_valid),
        .i_word_last  (i_word_last),
        .o_word_ready (o_word_ready),
        .o_coef       (o_coef),
        .o_coef_idx   (o_coef_idx),
        .o_coef_valid (o_coef_valid),
        .i_coef_ready (i_coef_ready),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [19:0] exp_q[$];
    int          rx_count = 0;
    int          done_seen = 0;
    int          rdy_viol = 0;
    bit          bp_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [11:0] prev_coef;
    logic [7:0]  prev_idx;
    logic [19:0] mon_e;
    logic [63:0] poly_q[$];
    logic [63:0] dir_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic offer(input int d, inout int cnt);
        if (d < 3329 && cnt < 256) begin
            exp_q.push_back({12'(d), 8'(cnt)});
            cnt++;
        end
    endtask

    // Byte-level reference parse: d1 = b0 + 256*(b1 mod 16), d2 = b1/16 + 16*b2.
    task automatic model(input logic [63:0] ws[$], output bit exp_err);
        logic [7:0]  b[$];
        logic [63:0] w;
        int          cnt = 0;
        foreach (ws[i]) begin
            w = ws[i];
            for (int k = 0; k < 8; k++) b.push_back(w[63-8*k -: 8]);
        end
        for (int i = 0; i + 2 < b.size(); i += 3) begin
            offer(int'(b[i]) + 256 * (int'(b[i+1]) % 16), cnt);
            offer(int'(b[i+1]) / 16 + 16 * int'(b[i+2]), cnt);
        end
        if (b.size() % 3 == 2)
            offer(int'(b[b.size()-2]) + 256 * (int'(b[b.size()-1]) % 16), cnt);
        exp_err = (cnt < 256);
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w, input logic last);
        int t = 0;
        i_word = w; i_word_last = last; i_word_valid = 1'b1;
        @(negedge i_clk);
        while (!o_word_ready && t < 2000) begin
            t++;
            @(negedge i_clk);
        end
        if (t >= 2000) chk("word_accept_timeout", 32'(o_word_ready), 32'd1);
        @(posedge i_clk); #1;
        i_word_valid = 1'b0; i_word_last = 1'b0;
    endtask

    task automatic run_words(input logic [63:0] ws[$]);
        foreach (ws[i]) send_word(ws[i], i == ws.size() - 1);
    endtask

    task automatic wait_done(input bit exp_err);
        int t = 0;
        while (done_seen == 0 && t < 3000) begin
            @(negedge i_clk);
            t++;
        end
        chk("done_seen", 32'(done_seen != 0), 32'd1);
        chk("err", 32'(o_err), 32'(exp_err));
        repeat (3) @(negedge i_clk);
        chk("done_once", 32'(done_seen), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        @(posedge i_clk); #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_word_ready"}, 32'(o_word_ready), 32'd0);
        chk({tag, "_coef"}, 32'(o_coef), 32'd0);
        chk({tag, "_coef_idx"}, 32'(o_coef_idx), 32'd0);
        chk({tag, "_coef_valid"}, 32'(o_coef_valid), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_err"}, 32'(o_err), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every output handshake, checks hold-while-stalled.
    always @(negedge i_clk) begin
        if (i_rstn) begin
            if (o_done) done_seen++;
            if (dut.r_fill > 8'd64 && o_word_ready) rdy_viol++;
            if (stall_prev) begin
                chk("hold_valid", 32'(o_coef_valid), 32'd1);
                chk("hold_coef", 32'(o_coef), 32'(prev_coef));
                chk("hold_idx", 32'(o_coef_idx), 32'(prev_idx));
            end
            stall_prev = o_coef_valid && !i_coef_ready;
            prev_coef  = o_coef;
            prev_idx   = o_coef_idx;
            if (o_coef_valid && i_coef_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_coef", 32'(o_coef_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("coef", 32'(o_coef), 32'(mon_e[19:8]));
                    chk("coef_idx", 32'(o_coef_idx), 32'(mon_e[7:0]));
                    rx_count++;
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge i_clk); #1;
            i_coef_ready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    initial begin
        bit e_err;
        int rx0;
        int t;
        i_rstn = 1'b0; i_start = 1'b0; i_word = '0;
        i_word_valid = 1'b0; i_word_last = 1'b0; i_coef_ready = 1'b1;
        for (int i = 0; i < 63; i++) poly_q.push_back({$urandom, $urandom});

        #12;
        chk_outputs_zero("reset");
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        repeat (2) @(posedge i_clk); #1;

        // Directed: basic parse and rejection boundary (3329 dropped, 3328 kept).
        exp_q.push_back({12'd3327, 8'd0});
        exp_q.push_back({12'd256,  8'd1});
        for (int i = 2; i <= 6; i++) exp_q.push_back({12'd0, 8'(i)});
        exp_q.push_back({12'd3328, 8'd7});
        exp_q.push_back({12'd291,  8'd8});
        exp_q.push_back({12'd3328, 8'd9});
        exp_q.push_back({12'd1042, 8'd10});
        exp_q.push_back({12'd1379, 8'd11});
        done_seen = 0;
        start_pulse();
        send_word(64'hFF0C_1000_0000_0000, 1'b0);
        @(negedge i_clk);
        chk("latency_not_yet", 32'(o_coef_valid), 32'd0);
        @(posedge i_clk); #1;
        chk("latency_valid", 32'(o_coef_valid), 32'd1);
        chk("latency_coef", 32'(o_coef), 32'd3327);
        send_word(64'h0001_0D00_000D_FF23, 1'b0);
        send_word(64'h01D0_FFFF_FF12_3456, 1'b1);
        wait_done(1'b1);

        // Full polynomial, always ready.
        done_seen = 0;
        model(poly_q, e_err);
        start_pulse();
        run_words(poly_q);
        wait_done(e_err);

        // Same stream under random backpressure.
        done_seen = 0;
        bp_en = 1'b1;
        model(poly_q, e_err);
        start_pulse();
        run_words(poly_q);
        wait_done(e_err);
        bp_en = 1'b0;

        // Starvation: all candidates are 4095.
        done_seen = 0;
        dir_q.delete();
        repeat (4) dir_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        start_pulse();
        run_words(dir_q);
        wait_done(1'b1);

        // Reset mid-polynomial after 100 coefficients.
        model(poly_q, e_err);
        rx0 = rx_count;
        start_pulse();
        for (int i = 0; i < poly_q.size() && rx_count < rx0 + 100; i++)
            send_word(poly_q[i], i == poly_q.size() - 1);
        t = 0;
        while (rx_count < rx0 + 100 && t < 2000) begin
            @(negedge i_clk);
            t++;
        end
        chk("reached_100", 32'(rx_count >= rx0 + 100), 32'd1);
        @(posedge i_clk); #3;
        i_rstn = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        exp_q.delete();
        repeat (3) @(posedge i_clk); #1;
        i_rstn = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("post_reset_quiet", 32'(o_coef_valid), 32'd0);
        @(posedge i_clk); #1;

        // Restart from idx 0; a start pulse while running is ignored.
        done_seen = 0;
        model(poly_q, e_err);
        start_pulse();
        for (int i = 0; i < poly_q.size(); i++) begin
            if (i == 10) start_pulse();
            send_word(poly_q[i], i == poly_q.size() - 1);
        end
        wait_done(e_err);

        chk("ready_low_when_full", 32'(rdy_viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
